// File: rtl/fnc_timer_mc.sv
`default_nettype none
// ============================================================================
//  Module   : fnc_timer_mc
//  Purpose  : Free-running machine timer (mtime) with a programmable
//             prescaler, load and enable, plus NCH independent compare
//             channels. Each channel runs in level mode (mtimecmp style)
//             or in periodic auto-reload mode.
//  Options  : FNC_TIMER_PEND_EN adds int_clr / int_pend sticky pending bits.
//  Revision : 1.0 - initial release
// ============================================================================
module fnc_timer_mc #(
  parameter int WIDTH = 64,
  parameter int NCH   = 4,
  parameter int PSC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PSC_W-1:0]     psc,
  input  logic                 mtime_we,
  input  logic [WIDTH-1:0]     mtime_wdata,
  input  logic [NCH-1:0]       cmp_we,
  input  logic [WIDTH-1:0]     cmp_wdata,
  input  logic [NCH-1:0]       cmp_mode,
  input  logic [NCH*WIDTH-1:0] cmp_prd,
`ifdef FNC_TIMER_PEND_EN
  input  logic [NCH-1:0]       int_clr,
  output logic [NCH-1:0]       int_pend,
`endif
  output logic [WIDTH-1:0]     mtime,
  output logic [NCH*WIDTH-1:0] mtimecmp,
  output logic                 tick,
  output logic [NCH-1:0]       int_timer
);

  localparam logic [WIDTH-1:0] c_mtime_one = WIDTH'(1);
  localparam logic [PSC_W-1:0] c_pcnt_one  = PSC_W'(1);

  logic [WIDTH-1:0] mtime_q, mtime_d;
  logic [PSC_W-1:0] pcnt_q,  pcnt_d;
  logic             tick_q,  tick_d;

  // Next counter state: a load beats an increment and never counts as a tick.
  always_comb begin
    mtime_d = mtime_q;
    pcnt_d  = pcnt_q;
    tick_d  = 1'b0;
    if (mtime_we) begin
      mtime_d = mtime_wdata;
      pcnt_d  = '0;
    end else if (en) begin
      // >= rather than == so that lowering psc below pcnt fires at once
      if (pcnt_q >= psc) begin
        pcnt_d  = '0;
        mtime_d = mtime_q + c_mtime_one;
        tick_d  = 1'b1;
      end else begin
        pcnt_d  = pcnt_q + c_pcnt_one;
      end
    end
  end

  // Counter, prescaler and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= '0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
    end
  end

  assign mtime = mtime_q;
  assign tick  = tick_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] prd;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             int_q, int_d;
    logic             hit;
    logic             periodic;

    assign prd      = cmp_prd[i*WIDTH +: WIDTH];
    assign hit      = (mtime_q >= cmp_q);
    // A zero period degenerates to level behaviour (no reload).
    assign periodic = cmp_mode[i] && (prd != '0);

    // Compare register update; a software write overrides a reload, and the
    // interrupt follows this cycle's hit in both modes (the reload is what
    // makes the periodic output a single-cycle pulse).
    always_comb begin
      cmp_d = cmp_q;
      int_d = hit;
      if (periodic && hit) begin
        cmp_d = cmp_q + prd;
      end
      if (cmp_we[i]) begin
        cmp_d = cmp_wdata;
      end
    end

    // Per-channel compare and interrupt registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmp_q <= '1;
        int_q <= 1'b0;
      end else begin
        cmp_q <= cmp_d;
        int_q <= int_d;
      end
    end

    assign mtimecmp[i*WIDTH +: WIDTH] = cmp_q;
    assign int_timer[i]               = int_q;

`ifdef FNC_TIMER_PEND_EN
    logic pend_q, pend_d;
    logic fire;

    // Level mode latches only the rising edge; periodic latches every pulse.
    always_comb begin
      fire   = hit && (periodic || !int_q);
      pend_d = fire || (pend_q && !int_clr[i]);
    end

    // Sticky pending bit; a new event wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= pend_d;
      end
    end

    assign int_pend[i] = pend_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_fnc_timer_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnc_timer_mc
//  Purpose  : Self-checking bench for fnc_timer_mc: directed scenarios plus
//             randomized traffic checked against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnc_timer_mc;
  localparam int WIDTH = 64;
  localparam int NCH   = 4;
  localparam int PSC_W = 8;
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [PSC_W-1:0]     psc;
  logic                 mtime_we;
  logic [WIDTH-1:0]     mtime_wdata;
  logic [NCH-1:0]       cmp_we;
  logic [WIDTH-1:0]     cmp_wdata;
  logic [NCH-1:0]       cmp_mode;
  logic [NCH*WIDTH-1:0] cmp_prd;
  logic [WIDTH-1:0]     mtime;
  logic [NCH*WIDTH-1:0] mtimecmp;
  logic                 tick;
  logic [NCH-1:0]       int_timer;
  logic [NCH-1:0]       clr_v;
`ifdef FNC_TIMER_PEND_EN
  logic [NCH-1:0]       int_clr;
  logic [NCH-1:0]       int_pend;
  assign clr_v = int_clr;
`else
  assign clr_v = '0;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural reference state
  logic [WIDTH-1:0] m_mtime;
  int unsigned      m_pcnt;
  logic [WIDTH-1:0] m_cmp [NCH];
  logic [NCH-1:0]   m_int;
  logic [NCH-1:0]   m_pend;
  logic             m_tick;

  fnc_timer_mc #(.WIDTH(WIDTH), .NCH(NCH), .PSC_W(PSC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .psc(psc),
    .mtime_we(mtime_we), .mtime_wdata(mtime_wdata),
    .cmp_we(cmp_we), .cmp_wdata(cmp_wdata), .cmp_mode(cmp_mode),
    .cmp_prd(cmp_prd),
`ifdef FNC_TIMER_PEND_EN
    .int_clr(int_clr), .int_pend(int_pend),
`endif
    .mtime(mtime), .mtimecmp(mtimecmp), .tick(tick), .int_timer(int_timer)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] prd_of(int i);
    return cmp_prd[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] cmp_of(int i);
    return mtimecmp[i*WIDTH +: WIDTH];
  endfunction

  // One clock: the model computes the next state from the spec rules using
  // the inputs presented before the edge, then outputs are sampled at +1.
  task automatic step();
    logic [WIDTH-1:0] n_mtime;
    int unsigned      n_pcnt;
    logic             n_tick;
    logic [WIDTH-1:0] n_cmp [NCH];
    logic [NCH-1:0]   n_int, n_pend;
    if (rst) begin
      n_mtime = '0; n_pcnt = 0; n_tick = 1'b0; n_int = '0; n_pend = '0;
      for (int i = 0; i < NCH; i++) n_cmp[i] = ALL1;
    end else begin
      n_mtime = m_mtime; n_pcnt = m_pcnt; n_tick = 1'b0;
      if (mtime_we) begin
        n_mtime = mtime_wdata; n_pcnt = 0;
      end else if (en) begin
        if (m_pcnt >= int'(psc)) begin
          n_pcnt = 0; n_mtime = m_mtime + 64'd1; n_tick = 1'b1;
        end else begin
          n_pcnt = m_pcnt + 1;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        logic h, per, fire;
        h   = (m_mtime >= m_cmp[i]);
        per = cmp_mode[i] && (prd_of(i) != 0);
        n_int[i] = h;
        n_cmp[i] = m_cmp[i];
        if (per && h) n_cmp[i] = m_cmp[i] + prd_of(i);
        if (cmp_we[i]) n_cmp[i] = cmp_wdata;
        fire = per ? h : (h && !m_int[i]);
        n_pend[i] = fire || (m_pend[i] && !clr_v[i]);
      end
    end
    @(posedge clk);
    #1;
    m_mtime = n_mtime; m_pcnt = n_pcnt; m_tick = n_tick;
    m_int = n_int; m_pend = n_pend;
    for (int i = 0; i < NCH; i++) m_cmp[i] = n_cmp[i];
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; psc = '0; mtime_we = 1'b0; mtime_wdata = '0;
    cmp_we = '0; cmp_wdata = '0; cmp_mode = '0; cmp_prd = '0;
`ifdef FNC_TIMER_PEND_EN
    int_clr = '0;
`endif
    repeat (10) step();
    checks++;
    if (mtime !== 64'd0) begin
      errors++; $display("FAIL reset_mtime: actual=%h required=0", mtime);
    end
    checks++;
    if (int_timer !== 4'b0) begin
      errors++; $display("FAIL reset_int: actual=%b required=0000", int_timer);
    end
    checks++;
    if (cmp_of(0) !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_cmp0: actual=%h required=ffffffffffffffff", cmp_of(0));
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: actual=%b required=0", tick);
    end
    rst = 1'b0; en = 1'b1; psc = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick !== 1'b1) begin
        errors++; $display("FAIL run_tick: cycle=%0d actual=%b required=1", k, tick);
      end
    end
    checks++;
    if (mtime !== 64'd10) begin
      errors++; $display("FAIL run_mtime: actual=%0d required=10", mtime);
    end
  endtask

  task automatic test_level();
    cmp_we = 4'b0001; cmp_wdata = 64'd16;
    step();
    cmp_we = '0;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++;
      if (int_timer[0] !== ((10 + k) >= 16)) begin
        errors++;
        $display("FAIL level_int0: mtime=%0d actual=%b required=%b", mtime, int_timer[0], (10 + k) >= 16);
      end
    end
    cmp_we = 4'b0001; cmp_wdata = 64'd100;
    step();
    cmp_we = '0;
    checks++;
    if (int_timer[0] !== 1'b1) begin
      errors++; $display("FAIL level_hold_on_write: actual=%b required=1", int_timer[0]);
    end
    step();
    checks++;
    if (int_timer[0] !== 1'b0) begin
      errors++; $display("FAIL level_fall: actual=%b required=0", int_timer[0]);
    end
  endtask

  task automatic test_prescaler();
    logic [WIDTH-1:0] base;
    int ticks;
    base = m_mtime; ticks = 0; psc = 8'd3;
    for (int k = 0; k < 16; k++) begin
      step();
      if (tick === 1'b1) ticks++;
    end
    checks++;
    if (ticks !== 4) begin
      errors++; $display("FAIL psc_ticks: actual=%0d required=4", ticks);
    end
    checks++;
    if (mtime !== base + 64'd4) begin
      errors++; $display("FAIL psc_mtime: actual=%0d required=%0d", mtime, base + 64'd4);
    end
    en = 1'b0; ticks = 0;
    repeat (5) begin
      step();
      if (tick === 1'b1) ticks++;
    end
    checks++;
    if (mtime !== base + 64'd4 || ticks !== 0) begin
      errors++; $display("FAIL en_hold: actual=%0d ticks=%0d required=%0d ticks=0", mtime, ticks, base + 64'd4);
    end
    en = 1'b1; psc = '0;
  endtask

  task automatic test_periodic();
    int pulses;
    logic exp;
    pulses = 0;
    mtime_we = 1'b1; mtime_wdata = '0;
    cmp_we = 4'b0010; cmp_wdata = 64'd20;
    cmp_mode[1] = 1'b1; cmp_prd[1*WIDTH +: WIDTH] = 64'd5;
    step();
    mtime_we = 1'b0; cmp_we = '0;
    for (int k = 1; k <= 33; k++) begin
      step();
      exp = ((k - 1) == 20) || ((k - 1) == 25) || ((k - 1) == 30);
      if (int_timer[1] === 1'b1) pulses++;
      checks++;
      if (int_timer[1] !== exp) begin
        errors++; $display("FAIL periodic_int1: mtime=%0d actual=%b required=%b", mtime, int_timer[1], exp);
      end
    end
    checks++;
    if (pulses !== 3 || cmp_of(1) !== 64'd35) begin
      errors++; $display("FAIL periodic_reload: pulses=%0d cmp=%0d required pulses=3 cmp=35", pulses, cmp_of(1));
    end
    repeat (2) step();
    cmp_we = 4'b0010; cmp_wdata = 64'd50;
    step();
    cmp_we = '0;
    checks++;
    if (int_timer[1] !== 1'b1 || cmp_of(1) !== 64'd50) begin
      errors++; $display("FAIL periodic_write_wins: int=%b cmp=%0d required int=1 cmp=50", int_timer[1], cmp_of(1));
    end
  endtask

  task automatic test_wrap();
    mtime_we = 1'b1; mtime_wdata = 64'hFFFF_FFFF_FFFF_FFFE;
    cmp_we = 4'b0001; cmp_wdata = 64'd5;
    step();
    mtime_we = 1'b0; cmp_we = '0;
    checks++;
    if (mtime !== 64'hFFFF_FFFF_FFFF_FFFE || tick !== 1'b0) begin
      errors++; $display("FAIL load_priority: mtime=%h tick=%b required fffffffffffffffe tick=0", mtime, tick);
    end
    step();
    checks++;
    if (mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL wrap_max: actual=%h required=ffffffffffffffff", mtime);
    end
    step();
    checks++;
    if (mtime !== 64'd0 || int_timer[0] !== 1'b1) begin
      errors++; $display("FAIL wrap_zero: mtime=%h int0=%b required 0 int0=1", mtime, int_timer[0]);
    end
    step();
    checks++;
    if (int_timer[0] !== 1'b0) begin
      errors++; $display("FAIL wrap_level_drop: actual=%b required=0", int_timer[0]);
    end
  endtask

`ifdef FNC_TIMER_PEND_EN
  task automatic test_pend();
    bit seen;
    int_clr = 4'b0001;
    step();
    int_clr = '0;
    checks++;
    if (int_pend[0] !== 1'b0) begin
      errors++; $display("FAIL pend_clear0: actual=%b required=0", int_pend[0]);
    end
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (int_timer[0] === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || int_pend[0] !== 1'b1) begin
      errors++; $display("FAIL pend_level_set: int0=%b pend0=%b required 1 1", int_timer[0], int_pend[0]);
    end
    cmp_we = 4'b0001; cmp_wdata = m_mtime + 64'd1000;
    step();
    cmp_we = '0;
    step();
    checks++;
    if (int_timer[0] !== 1'b0 || int_pend[0] !== 1'b1) begin
      errors++; $display("FAIL pend_sticky: int0=%b pend0=%b required int0=0 pend0=1", int_timer[0], int_pend[0]);
    end
    int_clr = 4'b0001;
    step();
    int_clr = '0;
    checks++;
    if (int_pend[0] !== 1'b0) begin
      errors++; $display("FAIL pend_clr: actual=%b required=0", int_pend[0]);
    end
    cmp_mode[1] = 1'b1; cmp_prd[1*WIDTH +: WIDTH] = 64'd5;
    cmp_we = 4'b0010; cmp_wdata = m_mtime + 64'd2; int_clr = 4'b0010;
    step();
    cmp_we = '0; int_clr = '0;
    checks++;
    if (int_pend[1] !== 1'b0) begin
      errors++; $display("FAIL pend_clr1: actual=%b required=0", int_pend[1]);
    end
    step();
    int_clr = 4'b0010;
    step();
    int_clr = '0;
    checks++;
    if (int_timer[1] !== 1'b1 || int_pend[1] !== 1'b1) begin
      errors++; $display("FAIL pend_set_wins: int1=%b pend1=%b required 1 1", int_timer[1], int_pend[1]);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      en = ($urandom_range(0, 7) != 0);
      psc = PSC_W'($urandom_range(0, 3));
      mtime_we = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0)
        mtime_wdata = ALL1 - 64'($urandom_range(0, 15));
      else
        mtime_wdata = m_mtime + 64'($urandom_range(0, 40));
      cmp_we = ($urandom_range(0, 7) == 0) ? NCH'(1 << $urandom_range(0, NCH - 1)) : '0;
      cmp_wdata = m_mtime + 64'($urandom_range(0, 30));
      if ($urandom_range(0, 15) == 0) cmp_mode = NCH'($urandom);
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < NCH; i++) cmp_prd[i*WIDTH +: WIDTH] = 64'($urandom_range(0, 6));
`ifdef FNC_TIMER_PEND_EN
      int_clr = NCH'($urandom) & NCH'($urandom);
`endif
      step();
      checks++;
      if (mtime !== m_mtime) begin
        errors++; $display("FAIL rand_mtime: cycle=%0d actual=%h required=%h", k, mtime, m_mtime);
      end
      checks++;
      if (tick !== m_tick) begin
        errors++; $display("FAIL rand_tick: cycle=%0d actual=%b required=%b", k, tick, m_tick);
      end
      checks++;
      if (int_timer !== m_int) begin
        errors++; $display("FAIL rand_int: cycle=%0d actual=%b required=%b", k, int_timer, m_int);
      end
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (cmp_of(i) !== m_cmp[i]) begin
          errors++; $display("FAIL rand_cmp%0d: cycle=%0d actual=%h required=%h", i, k, cmp_of(i), m_cmp[i]);
        end
      end
`ifdef FNC_TIMER_PEND_EN
      checks++;
      if (int_pend !== m_pend) begin
        errors++; $display("FAIL rand_pend: cycle=%0d actual=%b required=%b", k, int_pend, m_pend);
      end
`endif
    end
    mtime_we = 1'b0; cmp_we = '0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_prescaler();
    test_periodic();
    test_wrap();
`ifdef FNC_TIMER_PEND_EN
    test_pend();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
